// File: rtl/mdu_ctrl_pkg.sv
// Shared definitions for the multiply/divide unit sequencer.
// Contents: MDU operation encodings, FSM state type and op-class helpers.
// Optional feature macro: MDU_MADD_EN (adds MADD/MADDU to the multiply class).
package mdu_ctrl_pkg;

  // Operation encodings carried on mdOp_E.
  localparam logic [3:0] MDOP_NONE  = 4'd0;
  localparam logic [3:0] MDOP_MULT  = 4'd1;
  localparam logic [3:0] MDOP_MULTU = 4'd2;
  localparam logic [3:0] MDOP_DIV   = 4'd3;
  localparam logic [3:0] MDOP_DIVU  = 4'd4;
  localparam logic [3:0] MDOP_MFHI  = 4'd5;
  localparam logic [3:0] MDOP_MFLO  = 4'd6;
  localparam logic [3:0] MDOP_MTHI  = 4'd7;
  localparam logic [3:0] MDOP_MTLO  = 4'd8;
  localparam logic [3:0] MDOP_MADD  = 4'd9;
  localparam logic [3:0] MDOP_MADDU = 4'd10;

  typedef enum logic [1:0] {
    MDU_IDLE = 2'd0,
    MDU_MUL  = 2'd1,
    MDU_DIV  = 2'd2
  } mdu_state_e;

  // Ops that run through the multi-cycle multiply path.
  function automatic logic is_mul_op(input logic [3:0] op);
`ifdef MDU_MADD_EN
    return (op == MDOP_MULT) || (op == MDOP_MULTU) ||
           (op == MDOP_MADD) || (op == MDOP_MADDU);
`else
    return (op == MDOP_MULT) || (op == MDOP_MULTU);
`endif
  endfunction

  // Ops that run through the multi-cycle divide path.
  function automatic logic is_div_op(input logic [3:0] op);
    return (op == MDOP_DIV) || (op == MDOP_DIVU);
  endfunction

endpackage

// File: rtl/mdu_ctrl_calc.sv
// mdu_calc: combinational 64-bit result {pHi,pLo} for the multi-cycle ops.
// Ports:
//   op_i     [3:0]  operation code (MDOP_*)
//   src_a_i  [31:0] rs operand (multiplicand / dividend)
//   src_b_i  [31:0] rt operand (multiplier / divisor)
//   hi_i     [31:0] current HI (accumulate base, divide-by-zero result)
//   lo_i     [31:0] current LO
//   res_o    [63:0] {hi, lo} to be committed when the op finishes
// Optional feature macro: MDU_MADD_EN (MADD/MADDU accumulate into {hi,lo}).
module mdu_calc
  import mdu_ctrl_pkg::*;
(
  input  logic [3:0]  op_i,
  input  logic [31:0] src_a_i,
  input  logic [31:0] src_b_i,
  input  logic [31:0] hi_i,
  input  logic [31:0] lo_i,
  output logic [63:0] res_o
);

  logic [63:0] a_sx, b_sx, a_zx, b_zx;
  logic [63:0] prod_s, prod_u;
  logic [31:0] dvd_mag, dvs_mag, dvs_mag_safe, dvs_u_safe;
  logic [31:0] q_mag, r_mag, quo_s, rem_s, quo_u, rem_u;
  logic        b_zero;

  // The low 64 bits of a 64x64 product of sign-extended operands equal
  // the signed 32x32 product, so one unsigned multiplier form serves both.
  assign a_sx   = {{32{src_a_i[31]}}, src_a_i};
  assign b_sx   = {{32{src_b_i[31]}}, src_b_i};
  assign a_zx   = {32'd0, src_a_i};
  assign b_zx   = {32'd0, src_b_i};
  assign prod_s = a_sx * b_sx;
  assign prod_u = a_zx * b_zx;

  // Signed divide on magnitudes: quotient truncates toward zero and the
  // remainder takes the dividend's sign. 0x80000000 / -1 falls out as
  // quotient 0x80000000, remainder 0 without special casing.
  assign b_zero       = (src_b_i == 32'd0);
  assign dvd_mag      = src_a_i[31] ? (32'd0 - src_a_i) : src_a_i;
  assign dvs_mag      = src_b_i[31] ? (32'd0 - src_b_i) : src_b_i;
  // Divisor forced to 1 on zero so the dividers never see an undefined case.
  assign dvs_mag_safe = b_zero ? 32'd1 : dvs_mag;
  assign dvs_u_safe   = b_zero ? 32'd1 : src_b_i;
  assign q_mag        = dvd_mag / dvs_mag_safe;
  assign r_mag        = dvd_mag % dvs_mag_safe;
  assign quo_s        = (src_a_i[31] ^ src_b_i[31]) ? (32'd0 - q_mag) : q_mag;
  assign rem_s        = src_a_i[31] ? (32'd0 - r_mag) : r_mag;
  assign quo_u        = src_a_i / dvs_u_safe;
  assign rem_u        = src_a_i % dvs_u_safe;

  always_comb begin
    res_o = {hi_i, lo_i};
    case (op_i)
      MDOP_MULT:  res_o = prod_s;
      MDOP_MULTU: res_o = prod_u;
      // Divide by zero leaves HI/LO as they are.
      MDOP_DIV:   if (!b_zero) res_o = {rem_s, quo_s};
      MDOP_DIVU:  if (!b_zero) res_o = {rem_u, quo_u};
`ifdef MDU_MADD_EN
      MDOP_MADD:  res_o = {hi_i, lo_i} + prod_s;
      MDOP_MADDU: res_o = {hi_i, lo_i} + prod_u;
`endif
      default:    res_o = {hi_i, lo_i};
    endcase
  end

endmodule

// File: rtl/mdu_ctrl.sv
// mdu_ctrl: multiply/divide unit sequencer for the E stage.
// Accepts one MDU op per start pulse, holds busy for a fixed latency,
// commits the result into HI/LO and raises a D-stage stall request.
// Ports:
//   clk        clock, rising edge
//   reset      asynchronous active-high reset
//   start_E    E-stage instruction is an MDU op
//   mdOp_E     [3:0] operation code (MDOP_*)
//   srcA_E     [31:0] forwarded rs
//   srcB_E     [31:0] forwarded rt
//   mdUse_D    D-stage instruction is an MDU op
//   busy       multi-cycle op in flight
//   stall_D    D-stage stall request (combinational)
//   hi, lo     [31:0] current HI / LO
//   mdOut_E    [31:0] MFHI/MFLO read data (combinational)
//   dbg_state  [1:0] current FSM state (mdu_state_e)
// Handshake: an op is accepted on a rising edge where start_E is high and
// the FSM is IDLE; start_E while busy is dropped. stall_D keeps the D-stage
// op from reaching E until busy is low.
// Optional feature macro: MDU_MADD_EN (MADD/MADDU via the multiply path;
// when undefined those codes are no-ops).
module mdu_ctrl
  import mdu_ctrl_pkg::*;
#(
  parameter int MUL_LAT = 5,
  parameter int DIV_LAT = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_E,
  input  logic [3:0]  mdOp_E,
  input  logic [31:0] srcA_E,
  input  logic [31:0] srcB_E,
  input  logic        mdUse_D,
  output logic        busy,
  output logic        stall_D,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] mdOut_E,
  output logic [1:0]  dbg_state
);

  localparam logic [3:0] MUL_CNT = 4'(MUL_LAT);
  localparam logic [3:0] DIV_CNT = 4'(DIV_LAT);

  mdu_state_e  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] phi_q, plo_q;
  logic [31:0] hi_q, lo_q;
  logic [63:0] calc_res;
  logic        accept, op_mul, op_div, commit;

  assign op_mul = is_mul_op(mdOp_E);
  assign op_div = is_div_op(mdOp_E);
  assign accept = start_E && (state_q == MDU_IDLE);
  assign commit = (state_q != MDU_IDLE) && (cnt_q == 4'd1);

  mdu_calc u_calc (
    .op_i    (mdOp_E),
    .src_a_i (srcA_E),
    .src_b_i (srcB_E),
    .hi_i    (hi_q),
    .lo_i    (lo_q),
    .res_o   (calc_res)
  );

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= MDU_IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      MDU_IDLE: begin
        if (accept && op_mul) begin
          state_d = MDU_MUL;
          cnt_d   = MUL_CNT;
        end else if (accept && op_div) begin
          state_d = MDU_DIV;
          cnt_d   = DIV_CNT;
        end
      end
      MDU_MUL, MDU_DIV: begin
        if (cnt_q == 4'd1) begin
          state_d = MDU_IDLE;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin
        state_d = MDU_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // Output logic
  always_comb begin
    busy    = (state_q != MDU_IDLE);
    stall_D = mdUse_D && (busy || (start_E && (op_mul || op_div)));
  end

  // Pending result and architectural HI/LO
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phi_q <= 32'd0;
      plo_q <= 32'd0;
      hi_q  <= 32'd0;
      lo_q  <= 32'd0;
    end else begin
      if (accept && (op_mul || op_div)) begin
        phi_q <= calc_res[63:32];
        plo_q <= calc_res[31:0];
      end
      if (commit) begin
        hi_q <= phi_q;
        lo_q <= plo_q;
      end else if (accept && (mdOp_E == MDOP_MTHI)) begin
        hi_q <= srcA_E;
      end else if (accept && (mdOp_E == MDOP_MTLO)) begin
        lo_q <= srcA_E;
      end
    end
  end

  assign hi        = hi_q;
  assign lo        = lo_q;
  assign mdOut_E   = (mdOp_E == MDOP_MFLO) ? lo_q : hi_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed testbench for mdu_ctrl with hand-computed expected values.
module tb_mdu_ctrl;
  import mdu_ctrl_pkg::*;

  logic        clk;
  logic        reset;
  logic        start_E;
  logic [3:0]  mdOp_E;
  logic [31:0] srcA_E;
  logic [31:0] srcB_E;
  logic        mdUse_D;
  logic        busy;
  logic        stall_D;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] mdOut_E;
  logic [1:0]  dbg_state;

  int tests = 0;
  int fails = 0;

  mdu_ctrl #(.MUL_LAT(5), .DIV_LAT(10)) dut (
    .clk       (clk),
    .reset     (reset),
    .start_E   (start_E),
    .mdOp_E    (mdOp_E),
    .srcA_E    (srcA_E),
    .srcB_E    (srcB_E),
    .mdUse_D   (mdUse_D),
    .busy      (busy),
    .stall_D   (stall_D),
    .hi        (hi),
    .lo        (lo),
    .mdOut_E   (mdOut_E),
    .dbg_state (dbg_state)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // hazard contract: no new op while busy
  always @(posedge clk) begin
    if (!reset) begin
      assert (!(busy && start_E))
        else $error("FAIL hazard_contract busy=%0b start_E=%0b", busy, start_E);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
      else begin
        fails++;
        $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp)
      else begin
        fails++;
        $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
      end
  endtask

  // Multi-cycle op with mdUse_D held high: stall in the start cycle and
  // every busy cycle, busy for exactly lat cycles, both low afterwards.
  // Entered and left at a falling edge with start_E low.
  task automatic do_multi(input string tag, input logic [3:0] op,
                          input logic [31:0] a, input logic [31:0] b, input int lat);
    start_E = 1'b1;
    mdOp_E  = op;
    srcA_E  = a;
    srcB_E  = b;
    mdUse_D = 1'b1;
    #1;
    chk1({tag, "_stall_start"}, stall_D, 1'b1);
    chk1({tag, "_busy_start"}, busy, 1'b0);
    @(negedge clk);
    start_E = 1'b0;
    mdOp_E  = MDOP_NONE;
    for (int i = 0; i < lat; i++) begin
      #1;
      chk1($sformatf("%s_busy_c%0d", tag, i + 1), busy, 1'b1);
      chk1($sformatf("%s_stall_c%0d", tag, i + 1), stall_D, 1'b1);
      @(negedge clk);
    end
    #1;
    chk1({tag, "_busy_done"}, busy, 1'b0);
    chk1({tag, "_stall_done"}, stall_D, 1'b0);
    mdUse_D = 1'b0;
  endtask

  task automatic do_move(input string tag, input logic [3:0] op, input logic [31:0] a);
    start_E = 1'b1;
    mdOp_E  = op;
    srcA_E  = a;
    #1;
    chk1({tag, "_busy_start"}, busy, 1'b0);
    @(negedge clk);
    start_E = 1'b0;
    mdOp_E  = MDOP_NONE;
    #1;
    chk1({tag, "_busy_after"}, busy, 1'b0);
  endtask

  initial begin
    reset   = 1'b1;
    start_E = 1'b0;
    mdOp_E  = MDOP_NONE;
    srcA_E  = 32'd0;
    srcB_E  = 32'd0;
    mdUse_D = 1'b0;

    // reset state
    @(negedge clk);
    @(negedge clk);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_stall", stall_D, 1'b0);
    chk("rst_hi", hi, 32'h0);
    chk("rst_lo", lo, 32'h0);
    chk("rst_state", {30'd0, dbg_state}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // MULT signed: -1 * 2 = -2
    do_multi("mult", MDOP_MULT, 32'hFFFF_FFFF, 32'd2, 5);
    chk("mult_hi", hi, 32'hFFFF_FFFF);
    chk("mult_lo", lo, 32'hFFFF_FFFE);

    // MULTU: 0xFFFFFFFF * 2 = 0x1_FFFFFFFE
    do_multi("multu", MDOP_MULTU, 32'hFFFF_FFFF, 32'd2, 5);
    chk("multu_hi", hi, 32'h0000_0001);
    chk("multu_lo", lo, 32'hFFFF_FFFE);

    // DIV -7 / 2: q=-3, r=-1
    do_multi("div", MDOP_DIV, 32'hFFFF_FFF9, 32'd2, 10);
    chk("div_hi", hi, 32'hFFFF_FFFF);
    chk("div_lo", lo, 32'hFFFF_FFFD);

    // DIVU 7 / 0: full latency, HI/LO unchanged
    do_multi("divu0", MDOP_DIVU, 32'd7, 32'd0, 10);
    chk("divu0_hi", hi, 32'hFFFF_FFFF);
    chk("divu0_lo", lo, 32'hFFFF_FFFD);

    // DIV 0x80000000 / -1: no trap
    do_multi("divovf", MDOP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 10);
    chk("divovf_hi", hi, 32'h0);
    chk("divovf_lo", lo, 32'h8000_0000);

    // DIVU 100 / 7 = 14 r 2
    do_multi("divu", MDOP_DIVU, 32'd100, 32'd7, 10);
    chk("divu_hi", hi, 32'd2);
    chk("divu_lo", lo, 32'd14);

    // MTHI then MFHI next cycle; MTLO then MFLO
    do_move("mthi", MDOP_MTHI, 32'h0000_1234);
    chk("mthi_hi", hi, 32'h0000_1234);
    start_E = 1'b1;
    mdOp_E  = MDOP_MFHI;
    #1;
    chk("mfhi_out", mdOut_E, 32'h0000_1234);
    @(negedge clk);
    start_E = 1'b0;
    chk1("mfhi_busy", busy, 1'b0);
    do_move("mtlo", MDOP_MTLO, 32'hCAFE_0055);
    chk("mtlo_lo", lo, 32'hCAFE_0055);
    chk("mtlo_hi_kept", hi, 32'h0000_1234);
    start_E = 1'b1;
    mdOp_E  = MDOP_MFLO;
    #1;
    chk("mflo_out", mdOut_E, 32'hCAFE_0055);
    @(negedge clk);
    start_E = 1'b0;
    mdOp_E  = MDOP_NONE;

    // Back-to-back: second op starts in the cycle busy falls
    do_multi("b2b_mul", MDOP_MULT, 32'd3, 32'hFFFF_FFFC, 5);
    chk("b2b_mul_hi", hi, 32'hFFFF_FFFF);
    chk("b2b_mul_lo", lo, 32'hFFFF_FFF4);
    do_multi("b2b_div", MDOP_DIV, 32'd100, 32'hFFFF_FFF9, 10);
    chk("b2b_div_hi", hi, 32'd2);
    chk("b2b_div_lo", lo, 32'hFFFF_FFF2);

    // Reset in the third busy cycle of a DIV
    start_E = 1'b1;
    mdOp_E  = MDOP_DIVU;
    srcA_E  = 32'd50;
    srcB_E  = 32'd3;
    @(negedge clk);
    start_E = 1'b0;
    mdOp_E  = MDOP_NONE;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk1("midrst_busy", busy, 1'b0);
    chk("midrst_hi", hi, 32'h0);
    chk("midrst_lo", lo, 32'h0);
    chk("midrst_state", {30'd0, dbg_state}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("postrst_hi", hi, 32'h0);
    do_multi("postrst_div", MDOP_DIV, 32'd9, 32'd2, 10);
    chk("postrst_div_hi", hi, 32'd1);
    chk("postrst_div_lo", lo, 32'd4);

`ifdef MDU_MADD_EN
    do_move("madd_mthi", MDOP_MTHI, 32'd0);
    do_move("madd_mtlo", MDOP_MTLO, 32'd5);
    do_multi("maddu", MDOP_MADDU, 32'd3, 32'd4, 5);
    chk("maddu_hi", hi, 32'd0);
    chk("maddu_lo", lo, 32'd17);
    do_multi("madd", MDOP_MADD, 32'hFFFF_FFFF, 32'd2, 5);
    chk("madd_hi", hi, 32'd0);
    chk("madd_lo", lo, 32'd15);
`else
    // MADD codes are no-ops: no stall, no busy, HI/LO unchanged
    start_E = 1'b1;
    mdOp_E  = MDOP_MADDU;
    srcA_E  = 32'd3;
    srcB_E  = 32'd4;
    mdUse_D = 1'b1;
    #1;
    chk1("maddoff_stall", stall_D, 1'b0);
    @(negedge clk);
    start_E = 1'b0;
    mdOp_E  = MDOP_NONE;
    #1;
    chk1("maddoff_busy", busy, 1'b0);
    chk1("maddoff_stall_after", stall_D, 1'b0);
    mdUse_D = 1'b0;
    @(negedge clk);
    chk("maddoff_hi", hi, 32'd1);
    chk("maddoff_lo", lo, 32'd4);
`endif

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule
